// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: byte width and the launch-sequencer state encoding.
// The encodings are shared with uart_tx and a future uart_rx, so keep them fixed.
package uart_tx_fifo_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous single-clock byte FIFO with a level counter.
// Ports:
//   clock_i, reset_i    clock and synchronous active-high reset (flushes the queue)
//   push_i, wdata_i     push request and byte; accepted when not full or popping
//   pop_i               pop request; ignored when empty
//   head_o              oldest queued byte, valid whenever empty_o is low
//   level_o             entries queued; full_o / empty_o derive from it
module uart_byte_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  logic [UART_BYTE_W-1:0] wdata_i,
  input  logic                   pop_i,
  output logic [UART_BYTE_W-1:0] head_o,
  output logic [ADDR_W:0]        level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned LevelW = ADDR_W + 1;

  logic [UART_BYTE_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]        count_q, count_d;
  logic                   push_ok, pop_ok;

  assign full_o  = (count_q == LevelW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  // Storage is flops, so the head is a registered value selected by rd_ptr.
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is still taken when a slot frees up in the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + LevelW'(1);
      2'b01:   count_d = count_q - LevelW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Contents need no reset: the pointers and count define what is valid.
  always_ff @(posedge clock_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer and launch sequencer in front of uart_tx. Queues bytes and issues one
// tx_start pulse per byte, paced by the serializer's busy flag.
// Ports:
//   clock, reset        clock and synchronous active-high reset
//   wr_en, wr_data      push a byte
//   full, empty, level  queue status (level excludes a byte already launched)
//   overflow            sticky: a push was dropped while full; cleared only by reset
//   tx_start, tx_data   launch pulse and byte to uart_tx; tx_data holds until next launch
//   tx_busy             busy flag from uart_tx
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [UART_BYTE_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        level,
  output logic                   overflow,
  output logic                   tx_start,
  output logic [UART_BYTE_W-1:0] tx_data,
  input  logic                   tx_busy
);

  seq_state_e             state_q, state_d;
  logic                   tx_start_q, tx_start_d;
  logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
  logic                   overflow_q, overflow_d;
  logic [UART_BYTE_W-1:0] head;
  logic                   fifo_pop;

  uart_byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clock_i (clock),
    .reset_i (reset),
    .push_i  (wr_en),
    .wdata_i (wr_data),
    .pop_i   (fifo_pop),
    .head_o  (head),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  // Launch only from idle with the serializer free, so tx_start never meets busy.
  assign fifo_pop = (state_q == S_IDLE) && !empty && !tx_busy;

  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    overflow_d = overflow_q || (wr_en && full && !fifo_pop);
    case (state_q)
      S_IDLE: begin
        if (fifo_pop) begin
          tx_data_d  = head;
          tx_start_d = 1'b1;
          state_d    = S_LAUNCH;
        end
      end
      S_LAUNCH:    state_d = S_WAIT_BUSY;
      // uart_tx raises busy the cycle after it samples start.
      S_WAIT_BUSY: if (tx_busy)  state_d = S_WAIT_DONE;
      // Also absorbs uart_tx's cleanup cycle.
      S_WAIT_DONE: if (!tx_busy) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo. A behavioural uart_tx (4 clocks per bit) drives tx_busy and a
// serial line built live from tx_data; a decoder rebuilds bytes from that line and they
// are compared against a queue of the bytes the FIFO is expected to accept.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int CPB   = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, overflow, tx_start, tx_busy;
  logic [4:0] level;
  logic [7:0] tx_data;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_fifo #(
    .DEPTH  (16),
    .ADDR_W (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural uart_tx + line decoder ----------------
  logic       u_busy = 1'b0;
  int         u_cnt  = 0;
  logic       u_line;
  logic [2:0] u_bidx;
  logic [7:0] u_sh = 8'h00;
  logic       u_start_ok = 1'b0;
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];
  int         start_cnt = 0;
  int         viol_cnt  = 0;

  assign tx_busy = u_busy;

  always_comb begin
    u_bidx = 3'((u_cnt - 4) / CPB);
    if (!u_busy)                  u_line = 1'b1;
    else if (u_cnt < CPB)         u_line = 1'b0;
    else if (u_cnt < 9 * CPB)     u_line = tx_data[u_bidx];
    else                          u_line = 1'b1;
  end

  always @(posedge clock) begin
    if (tx_start) start_cnt <= start_cnt + 1;
    if (tx_start && u_busy) viol_cnt <= viol_cnt + 1;
    if (reset) begin
      u_busy <= 1'b0;
      u_cnt  <= 0;
    end else if (!u_busy) begin
      if (tx_start) begin
        u_busy <= 1'b1;
        u_cnt  <= 0;
      end
    end else begin
      if (u_cnt == 2) u_start_ok <= (u_line == 1'b0);
      if (u_cnt >= 6 && u_cnt <= 34 && ((u_cnt - 6) % CPB) == 0)
        u_sh[3'((u_cnt - 6) / CPB)] <= u_line;
      if (u_cnt == 38 && u_line && u_start_ok) rx_q.push_back(u_sh);
      if (u_cnt == 10 * CPB) u_busy <= 1'b0;
      u_cnt <= u_cnt + 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_busy(input logic val, input string tag);
    int n = 0;
    while (tx_busy !== val && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check(tag, 32'(tx_busy), 32'(val));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((tx_busy || !empty || tx_start) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check("idle timeout", 32'(empty), 32'd1);
    repeat (3) tick();
  endtask

  task automatic drain_check(input string tag, input int budget);
    int n = 0;
    while (rx_q.size() < exp_q.size() && n < budget) begin
      tick();
      n++;
    end
    check({tag, " count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && rx_q.size() > 0)
      check({tag, " byte"}, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
    rx_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
    rx_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int         peak, s0, pending;
  logic [7:0] b;
  logic [7:0] hello [5];

  initial begin
    hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C; hello[3] = 8'h4C; hello[4] = 8'h4F;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check("rst tx_start", 32'(tx_start), 32'd0);
    check("rst tx_data", 32'(tx_data), 32'h00);
    check("rst overflow", 32'(overflow), 32'd0);
    check("rst level", 32'(level), 32'd0);
    check("rst empty", 32'(empty), 32'd1);
    check("rst full", 32'(full), 32'd0);
    reset = 1'b0;
    tick();

    // 1) Single byte: launch the cycle after the write, one pulse, data holds afterwards
    s0 = start_cnt;
    exp_q.push_back(8'h41);
    push_byte(8'h41);
    check("t1 no start yet", 32'(tx_start), 32'd0);
    check("t1 level after push", 32'(level), 32'd1);
    tick();
    check("t1 tx_start", 32'(tx_start), 32'd1);
    check("t1 tx_data", 32'(tx_data), 32'h41);
    check("t1 level after pop", 32'(level), 32'd0);
    tick();
    check("t1 pulse width", 32'(tx_start), 32'd0);
    drain_check("t1 rx", 400);
    wait_idle();
    check("t1 pulses", 32'(start_cnt - s0), 32'd1);
    check("t1 tx_data holds", 32'(tx_data), 32'h41);

    // 2) HELLO on consecutive cycles
    s0   = start_cnt;
    peak = 0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(hello[i]);
      wr_en   = 1'b1;
      wr_data = hello[i];
      tick();
      if (int'(level) > peak) peak = int'(level);
    end
    wr_en = 1'b0;
    check("t2 level peak", 32'(peak), 32'd4);
    drain_check("t2 rx", 1000);
    wait_idle();
    check("t2 pulses", 32'(start_cnt - s0), 32'd5);

    // 3) Overflow: 17 pushes while the serializer holds the one launched byte
    exp_q.push_back(8'hA0);
    push_byte(8'hA0);
    wait_busy(1'b1, "t3 busy");
    pending = 0;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      if (pending < DEPTH) begin
        exp_q.push_back(b);
        pending++;
      end
      push_byte(b);
    end
    check("t3 level", 32'(level), 32'(pending));
    check("t3 full", 32'(full), 32'd1);
    check("t3 overflow", 32'(overflow), 32'd1);
    drain_check("t3 rx", 1500);
    wait_idle();
    check("t3 overflow sticky", 32'(overflow), 32'd1);

    // 4) Full FIFO, push lands on the pop cycle
    do_reset();
    exp_q.push_back(8'hB0);
    push_byte(8'hB0);
    wait_busy(1'b1, "t4 busy");
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      push_byte(b);
    end
    check("t4 full before", 32'(full), 32'd1);
    wait_busy(1'b0, "t4 busy fall");
    // busy fell at the last edge; sequencer returns to idle next edge, pops the one after
    tick();
    b = 8'($urandom);
    exp_q.push_back(b);
    push_byte(b);
    check("t4 pop happened", 32'(tx_start), 32'd1);
    check("t4 level", 32'(level), 32'd16);
    check("t4 full after", 32'(full), 32'd1);
    check("t4 overflow", 32'(overflow), 32'd0);
    drain_check("t4 rx", 1500);
    wait_idle();
    check("t4 overflow end", 32'(overflow), 32'd0);

    // 5) Reset mid-frame with 3 bytes queued
    push_byte(8'hC0);
    wait_busy(1'b1, "t5 busy");
    push_byte(8'hC1);
    push_byte(8'hC2);
    push_byte(8'hC3);
    check("t5 level queued", 32'(level), 32'd3);
    repeat (8) tick();
    reset = 1'b1;
    tick();
    check("t5 level", 32'(level), 32'd0);
    check("t5 empty", 32'(empty), 32'd1);
    check("t5 tx_start", 32'(tx_start), 32'd0);
    reset = 1'b0;
    rx_q.delete();
    s0 = start_cnt;
    repeat (100) tick();
    check("t5 no pulses", 32'(start_cnt - s0), 32'd0);
    check("t5 no rx", 32'(rx_q.size()), 32'd0);

    // 6) Stream 40 random bytes at roughly one per frame; pointers wrap twice
    s0 = start_cnt;
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      push_byte(b);
      repeat ($urandom_range(40, 60)) tick();
    end
    drain_check("t6 rx", 2000);
    wait_idle();
    check("t6 pulses", 32'(start_cnt - s0), 32'd40);
    check("t6 overflow", 32'(overflow), 32'd0);
    check("start while busy", 32'(viol_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
